// File: rtl/multi_clock_divider.sv
// ---------------------------------------------------------------------------
// multi_clock_divider
//
// Produces NUM_CH independent square waves from one system clock. Each
// channel has a runtime-programmable half-period, a run enable, and a
// shadow register. New half-periods are only applied at a half-period
// boundary or while the channel is parked, so an output pulse is never cut
// short. A global sync pulse realigns every running channel to count 0 with
// the output low.
//
// Ports
//   clock_in    in   1        system clock, all logic on posedge
//   reset       in   1        asynchronous, active-low reset
//   enable      in   NUM_CH   per-channel run enable
//   sync        in   1        single-cycle realign pulse
//   load_valid  in   1        request to load a new half-period
//   load_ch     in   CH_W     target channel of the load
//   load_value  in   CNT_W    new half-period in clock_in cycles
//   load_ready  out  1        load accepted this cycle if load_valid is high
//   clock_out   out  NUM_CH   divided square-wave outputs
//   tick        out  NUM_CH   one-cycle pulse in the cycle clock_out toggles
//   pending     out  NUM_CH   shadow value waiting to be applied
// ---------------------------------------------------------------------------
module multi_clock_divider #(
    parameter int          NUM_CH      = 4,
    parameter int          CNT_W       = 32,
    parameter logic [31:0] DEFAULT_END = 32'd25_000_000,
    localparam int         CH_W        = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              clock_in,
    input  logic              reset,
    input  logic [NUM_CH-1:0] enable,
    input  logic              sync,
    input  logic              load_valid,
    input  logic [CH_W-1:0]   load_ch,
    input  logic [CNT_W-1:0]  load_value,
    output logic              load_ready,
    output logic [NUM_CH-1:0] clock_out,
    output logic [NUM_CH-1:0] tick,
    output logic [NUM_CH-1:0] pending
);

    localparam logic [CNT_W-1:0] DEF_HP = CNT_W'(DEFAULT_END);

    // Load handshake: a transfer happens on a clock edge where load_valid and
    // load_ready are both high. load_ready depends only on the addressed
    // channel's pending flag, never on load_valid, and is low for channel
    // numbers that do not exist. While a shadow is pending the channel refuses
    // further loads, so accept and apply can never hit the same channel in
    // the same cycle.
    always_comb begin
        load_ready = 1'b0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (load_ch == CH_W'(i)) begin
                load_ready = ~pending[i];
            end
        end
    end

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        logic [CNT_W-1:0] count_q;
        logic [CNT_W-1:0] hp_q;
        logic [CNT_W-1:0] shadow_q;
        logic [CNT_W-1:0] last_cnt;
        logic             out_q;
        logic             tick_q;
        logic             pend_q;
        logic             running;
        logic             terminal;
        logic             accept;

        // A half-period of 0 behaves as 1; clamping here avoids hp-1 wrapping.
        assign last_cnt = (hp_q == '0) ? '0 : hp_q - CNT_W'(1);
        assign terminal = (count_q >= last_cnt);
        // A channel whose enable dropped while high keeps running until it
        // has finished that high half and toggled low.
        assign running  = enable[g] | out_q;
        assign accept   = load_valid & load_ready & (load_ch == CH_W'(g));

        always_ff @(posedge clock_in or negedge reset) begin
            if (!reset) begin
                count_q  <= '0;
                hp_q     <= DEF_HP;
                shadow_q <= '0;
                out_q    <= 1'b0;
                tick_q   <= 1'b0;
                pend_q   <= 1'b0;
            end else begin
                tick_q <= 1'b0;

                if (accept) begin
                    shadow_q <= load_value;
                    pend_q   <= 1'b1;
                end

                if (running && sync) begin
                    // Realign: restart low with no tick, take any new period.
                    count_q <= '0;
                    out_q   <= 1'b0;
                    if (pend_q) begin
                        hp_q   <= shadow_q;
                        pend_q <= 1'b0;
                    end
                end else if (running) begin
                    if (terminal) begin
                        count_q <= '0;
                        out_q   <= ~out_q;
                        tick_q  <= 1'b1;
                        if (pend_q) begin
                            hp_q   <= shadow_q;
                            pend_q <= 1'b0;
                        end
                    end else begin
                        count_q <= count_q + CNT_W'(1);
                    end
                end else begin
                    // Parked low: nothing in flight, so a shadow applies now.
                    count_q <= '0;
                    if (pend_q) begin
                        hp_q   <= shadow_q;
                        pend_q <= 1'b0;
                    end
                end
            end
        end

        assign clock_out[g] = out_q;
        assign tick[g]      = tick_q;
        assign pending[g]   = pend_q;
    end

endmodule

// File: tb/tb_multi_clock_divider.sv
// ---------------------------------------------------------------------------
// tb_multi_clock_divider
//
// Directed scenarios followed by randomized traffic. A behavioural model
// tracks, per channel, how many cycles have elapsed in the current half
// period and compares that against the effective half length. Every driven
// cycle pushes the expected load_ready and the expected post-edge
// {clock_out, tick, pending} into queues; two monitor processes pop and
// compare them against the DUT.
// ---------------------------------------------------------------------------
module tb_multi_clock_divider;

    localparam int          NUM_CH  = 3;
    localparam int          CNT_W   = 16;
    localparam int          CH_W    = 2;
    localparam logic [31:0] DEF_END = 32'd3;
    localparam int          W       = 3 * NUM_CH;

    // ---------------- clock / reset ----------------
    logic              clock_in   = 1'b0;
    logic              reset      = 1'b1;
    logic [NUM_CH-1:0] enable     = '0;
    logic              sync       = 1'b0;
    logic              load_valid = 1'b0;
    logic [CH_W-1:0]   load_ch    = '0;
    logic [CNT_W-1:0]  load_value = '0;
    logic              load_ready;
    logic [NUM_CH-1:0] clock_out;
    logic [NUM_CH-1:0] tick;
    logic [NUM_CH-1:0] pending;

    always #5 clock_in = ~clock_in;

    multi_clock_divider #(
        .NUM_CH     (NUM_CH),
        .CNT_W      (CNT_W),
        .DEFAULT_END(DEF_END)
    ) dut (
        .clock_in  (clock_in),
        .reset     (reset),
        .enable    (enable),
        .sync      (sync),
        .load_valid(load_valid),
        .load_ch   (load_ch),
        .load_value(load_value),
        .load_ready(load_ready),
        .clock_out (clock_out),
        .tick      (tick),
        .pending   (pending)
    );

    // ---------------- scoreboard state ----------------
    int n_compared   = 0;
    int n_mismatched = 0;
    logic [W-1:0] exp_q[$];
    logic [0:0]   rdy_q[$];

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_compared++;
        if (act !== exp) begin
            n_mismatched++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic bound_fail(input string name);
        n_compared++;
        n_mismatched++;
        $display("FAIL %s: wait bound expired, got timeout expected event at %0t", name, $time);
    endtask

    // ---------------- reference model ----------------
    int unsigned m_elapsed[NUM_CH];
    int unsigned m_hp[NUM_CH];
    int unsigned m_shadow[NUM_CH];
    bit          m_out[NUM_CH];
    bit          m_tick[NUM_CH];
    bit          m_pend[NUM_CH];

    function automatic int unsigned half_len(input int unsigned v);
        return (v == 0) ? 1 : v;
    endfunction

    function automatic void model_reset();
        for (int i = 0; i < NUM_CH; i++) begin
            m_elapsed[i] = 0;
            m_hp[i]      = DEF_END;
            m_shadow[i]  = 0;
            m_out[i]     = 1'b0;
            m_tick[i]    = 1'b0;
            m_pend[i]    = 1'b0;
        end
    endfunction

    function automatic logic model_ready(input logic [CH_W-1:0] c);
        if (int'(c) >= NUM_CH) return 1'b0;
        return !m_pend[int'(c)];
    endfunction

    function automatic void apply_shadow(input int i);
        if (m_pend[i]) begin
            m_hp[i]   = m_shadow[i];
            m_pend[i] = 1'b0;
        end
    endfunction

    // One rising edge of behaviour, driven by the inputs present before it.
    function automatic void model_step(input logic [NUM_CH-1:0] en, input logic sy,
                                       input logic lv, input logic [CH_W-1:0] lc,
                                       input logic [CNT_W-1:0] lval);
        bit accept;
        bit busy;
        accept = lv && model_ready(lc);
        for (int i = 0; i < NUM_CH; i++) begin
            m_tick[i] = 1'b0;
            busy = en[i] || m_out[i];
            if (busy && sy) begin
                m_elapsed[i] = 0;
                m_out[i]     = 1'b0;
                apply_shadow(i);
            end else if (busy) begin
                m_elapsed[i]++;
                if (m_elapsed[i] >= half_len(m_hp[i])) begin
                    m_elapsed[i] = 0;
                    m_out[i]     = !m_out[i];
                    m_tick[i]    = 1'b1;
                    apply_shadow(i);
                end
            end else begin
                m_elapsed[i] = 0;
                apply_shadow(i);
            end
            if (accept && int'(lc) == i) begin
                m_shadow[i] = int'(lval);
                m_pend[i]   = 1'b1;
            end
        end
    endfunction

    function automatic logic [W-1:0] model_word();
        logic [NUM_CH-1:0] o, t, p;
        for (int i = 0; i < NUM_CH; i++) begin
            o[i] = m_out[i];
            t[i] = m_tick[i];
            p[i] = m_pend[i];
        end
        return {o, t, p};
    endfunction

    // ---------------- driver ----------------
    task automatic drive_cycle(input logic rst, input logic [NUM_CH-1:0] en, input logic sy,
                               input logic lv, input logic [CH_W-1:0] lc,
                               input logic [CNT_W-1:0] lval);
        @(negedge clock_in);
        reset      = rst;
        enable     = en;
        sync       = sy;
        load_valid = lv;
        load_ch    = lc;
        load_value = lval;
        if (!rst) begin
            model_reset();
            rdy_q.push_back(model_ready(lc));
        end else begin
            rdy_q.push_back(model_ready(lc));
            model_step(en, sy, lv, lc, lval);
        end
        exp_q.push_back(model_word());
    endtask

    task automatic idle(input int n, input logic [NUM_CH-1:0] en);
        for (int k = 0; k < n; k++) drive_cycle(1'b1, en, 1'b0, 1'b0, '0, '0);
    endtask

    task automatic async_reset_check();
        @(posedge clock_in);
        #3;
        reset = 1'b0;
        #1;
        check("async_reset", W'({clock_out, tick, pending}), '0);
        model_reset();
    endtask

    // ---------------- monitors ----------------
    initial begin : mon_ready
        logic [0:0] e;
        forever begin
            @(negedge clock_in);
            #2;
            if (rdy_q.size() > 0) begin
                e = rdy_q.pop_front();
                check("load_ready", W'(load_ready), W'(e));
            end
        end
    end

    initial begin : mon_outputs
        logic [W-1:0] e;
        forever begin
            @(posedge clock_in);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("out_tick_pend", {clock_out, tick, pending}, e);
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin : stim
        logic [NUM_CH-1:0] en;
        int guard;
        #1 reset = 1'b0;
        model_reset();

        // Reset state held for a few cycles.
        for (int k = 0; k < 3; k++) drive_cycle(1'b0, '0, 1'b0, 1'b0, '0, '0);

        // Release with all channels enabled at the default half-period.
        idle(20, '1);

        // Load ch0=5 when one cycle into a half, then retry while pending.
        guard = 0;
        while (!(m_elapsed[0] == 1 && !m_pend[0]) && guard < 20) begin
            idle(1, '1);
            guard++;
        end
        if (guard >= 20) bound_fail("wait_ch0_count1");
        drive_cycle(1'b1, '1, 1'b0, 1'b1, 2'd0, 16'd5);
        drive_cycle(1'b1, '1, 1'b0, 1'b1, 2'd0, 16'd9);
        idle(24, '1);

        // Half-periods of 0 and 1, plus a load to a nonexistent channel.
        drive_cycle(1'b1, '1, 1'b0, 1'b1, 2'd1, 16'd0);
        drive_cycle(1'b1, '1, 1'b0, 1'b1, 2'd2, 16'd1);
        drive_cycle(1'b1, '1, 1'b0, 1'b1, 2'd3, 16'd7);
        idle(12, '1);

        // ch1 at E=4: drop its enable while high, one cycle into the half.
        drive_cycle(1'b1, '1, 1'b0, 1'b1, 2'd1, 16'd4);
        guard = 0;
        while (!(m_out[1] && m_elapsed[1] == 1 && m_hp[1] == 4) && guard < 40) begin
            idle(1, '1);
            guard++;
        end
        if (guard >= 40) bound_fail("wait_ch1_high");
        idle(10, 3'b101);
        idle(4, '1);

        // E=3 and E=5 out of phase, then a sync pulse.
        drive_cycle(1'b1, '1, 1'b0, 1'b1, 2'd0, 16'd3);
        drive_cycle(1'b1, '1, 1'b0, 1'b1, 2'd2, 16'd5);
        idle(17, '1);
        drive_cycle(1'b1, '1, 1'b1, 1'b0, '0, '0);
        idle(12, '1);

        // Randomized traffic with an asynchronous reset in the middle.
        en = '1;
        for (int n = 0; n < 1500; n++) begin
            if (n == 700) begin
                guard = 0;
                while (!m_out[0] && guard < 40) begin
                    idle(1, 3'b001 | en);
                    guard++;
                end
                if (guard >= 40) bound_fail("wait_ch0_high");
                async_reset_check();
                drive_cycle(1'b0, en, 1'b0, 1'b0, '0, '0);
                drive_cycle(1'b0, en, 1'b0, 1'b0, '0, '0);
            end
            if ($urandom_range(0, 9) == 0) en = NUM_CH'($urandom);
            drive_cycle(1'b1, en,
                        ($urandom_range(0, 39) == 0),
                        ($urandom_range(0, 3) == 0),
                        CH_W'($urandom_range(0, 3)),
                        CNT_W'($urandom_range(0, 7)));
        end

        // Let the monitors drain the last expectations.
        repeat (2) @(posedge clock_in);
        #3;
        if (exp_q.size() != 0) bound_fail("exp_q_drain");
        if (rdy_q.size() != 0) bound_fail("rdy_q_drain");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
